bus_bridge: RTL and testbench
=============================

Name: bus_bridge

Overview:
- Sits directly downstream of the CPU core's data-bus port (Bus_addr/Bus_rdata/Bus_wen/Bus_wdata, driven from the MEM stage).
- Decodes each access to either the DRAM or one of four memory-mapped peripherals:
  - 8-digit 7-segment display
  - LED register
  - switch input
  - button input
- Owns the peripheral state: display/LED registers, the display scan counter and the input synchronisers.
- Returns read data combinationally within the same cycle, so the core can capture it into MEM/WB on the next edge.

Parameters:
- SCAN_DIV, 20000: cpu_clk cycles each display digit stays enabled before the scan advances. Legal range ≥ 2.
- DRAM_AW, 14: DRAM word-address width.

Ports:
- cpu_clk      in   1        core clock; all state updates on rising edge
- cpu_rst      in   1        asynchronous, active-low reset
- Bus_addr     in   32       byte address from core MEM stage
- Bus_wen      in   1        write enable from core
- Bus_wdata    in   32       write data from core
- Bus_rdata    out  32       read data to core (combinational)
- dram_addr    out  DRAM_AW  DRAM word address = Bus_addr[DRAM_AW+1:2]
- dram_we      out  1        DRAM write enable
- dram_wdata   out  32       = Bus_wdata
- dram_rdata   in   32       DRAM read data (combinational)
- sw           in   24       raw switches (asynchronous)
- btn          in   5        raw buttons (asynchronous)
- led          out  24       LED outputs, active-high
- dig_en       out  8        digit enables, active-low, one-hot-zero
- seg          out  8        segments {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Address decode, combinational, exact match on all 32 bits:
  - 0xFFFF_F000: display register DIG (R/W)
  - 0xFFFF_F060: LED register (R/W, bits [23:0]; upper bits read 0)
  - 0xFFFF_F070: switches (RO, {8'b0, sw_s})
  - 0xFFFF_F078: buttons (RO, {27'b0, btn_s})
  - any other address: DRAM.
- dram_we = Bus_wen only when the address decodes to DRAM. Peripheral writes never reach DRAM.
- Writes to SW/BTN addresses are ignored.
- Bus_rdata is a mux of dram_rdata, DIG, {8'b0,LED}, sw_s and btn_s by decode. There is no read side effect and no stall/handshake; every access completes in 1 cycle.
- DIG and LED update on the rising edge when Bus_wen=1 and the address matches. A write followed by a read of the same register on the next cycle returns the new value.
- Synchronisers: sw and btn each pass through 2 flops. sw_s and btn_s lag the pins by 2 edges.
- Display scan:
  - scan_cnt counts 0..SCAN_DIV-1, then wraps to 0 and increments the 3-bit digit index idx (7 wraps to 0).
  - dig_en = ~(8'b1 << idx).
  - seg = hex decode of DIG[4*idx+3 : 4*idx], dp always off (bit7 = 1).
  - Hex table (active-low, a = bit 0): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - seg is registered: it updates on the same edge as idx, so dig_en and seg always change together and never show a one-cycle mismatch.
- Reset (cpu_rst=0, asynchronous, any time including mid-scan):
  - DIG=0, LED=0, sync flops=0, scan_cnt=0, idx=0.
  - dig_en=8'hFE, seg=8'hC0, led=0.
  - Bus_rdata tracks decode combinationally even during reset.
- Simultaneous write to DIG on the edge where idx advances: seg for the new idx uses the old DIG. The new value appears at the next idx advance.

Test Plan:
- Reset with DIG written to 0x12345678 beforehand: assert cpu_rst=0 mid-scan → dig_en=FE, seg=C0, led=0 immediately, without waiting for a clock edge.
- Write 0xFFFF_F060 ← 0xA5A5A5A5 with Bus_wen=1 → led=0x A5A5A5 after the edge, dram_we=0 that cycle; read back returns 0x00A5A5A5.
- Write Bus_addr=0x0000_0010 ← 0xDEADBEEF → dram_we=1, dram_addr=4, dram_wdata=0xDEADBEEF. A read of the same address returns dram_rdata unchanged.
- Set SCAN_DIV=4 and write DIG=0x0000_00F1 → after 4 cycles dig_en=FD, seg=8E. At reset state (idx 0, DIG=0) seg=C0; for idx 0 with digit 1 → F9. After 32 cycles idx wraps back to 0.
- Step sw=0x00ABCD → reading 0xFFFF_F070 returns 0x00ABCD exactly 2 edges later, 0 before.
- Press btn=5'b10000 for 1 cycle → btn_s pulses 1 cycle, delayed 2 edges. A write to 0xFFFF_F078 leaves state and DRAM unchanged.

Source files
------------

// File: rtl/bus_bridge.sv
`timescale 1ns/1ps
// Data-bus bridge: decodes core accesses to DRAM or memory-mapped peripherals
// and owns the display, LED and input-synchroniser state.
module bus_bridge #(
    parameter int unsigned SCAN_DIV = 20000,
    parameter int unsigned DRAM_AW  = 14
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        Bus_addr,
    input  logic               Bus_wen,
    input  logic [31:0]        Bus_wdata,
    output logic [31:0]        Bus_rdata,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [31:0]        dram_rdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         seg
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    localparam logic [31:0] ADDR_DIG = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_LED = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW  = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN = 32'hFFFF_F078;

    logic [31:0]      dig_q, dig_d;
    logic [23:0]      led_q, led_d;
    logic [23:0]      sw_meta_q, sw_s_q;
    logic [4:0]       btn_meta_q, btn_s_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       seg_q, seg_d;

    logic sel_dig, sel_led, sel_sw, sel_btn, sel_dram;

    // Active-low seven-segment pattern, dp off
    function automatic logic [7:0] hex7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    always_comb begin
        sel_dig  = (Bus_addr == ADDR_DIG);
        sel_led  = (Bus_addr == ADDR_LED);
        sel_sw   = (Bus_addr == ADDR_SW);
        sel_btn  = (Bus_addr == ADDR_BTN);
        sel_dram = !(sel_dig || sel_led || sel_sw || sel_btn);
    end

    always_comb begin
        Bus_rdata = dram_rdata;
        if (sel_dig) begin
            Bus_rdata = dig_q;
        end else if (sel_led) begin
            Bus_rdata = {8'b0, led_q};
        end else if (sel_sw) begin
            Bus_rdata = {8'b0, sw_s_q};
        end else if (sel_btn) begin
            Bus_rdata = {27'b0, btn_s_q};
        end
    end

    assign dram_addr  = Bus_addr[DRAM_AW+1:2];
    assign dram_we    = Bus_wen && sel_dram;
    assign dram_wdata = Bus_wdata;
    assign led        = led_q;
    assign dig_en     = ~(8'd1 << idx_q);
    assign seg        = seg_q;

    // seg is loaded from the pre-write DIG on the same edge idx advances
    always_comb begin
        dig_d = dig_q;
        led_d = led_q;
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = idx_q;
        seg_d = seg_q;
        if (Bus_wen && sel_dig) begin
            dig_d = Bus_wdata;
        end
        if (Bus_wen && sel_led) begin
            led_d = Bus_wdata[23:0];
        end
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
            seg_d = hex7(dig_q[{idx_d, 2'b00} +: 4]);
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            dig_q      <= '0;
            led_q      <= '0;
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
            btn_meta_q <= '0;
            btn_s_q    <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            seg_q      <= 8'hC0;
        end else begin
            dig_q      <= dig_d;
            led_q      <= led_d;
            sw_meta_q  <= sw;
            sw_s_q     <= sw_meta_q;
            btn_meta_q <= btn;
            btn_s_q    <= btn_meta_q;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
        end
    end

endmodule

// File: tb/tb_bus_bridge.sv
`timescale 1ns/1ps
// Scoreboard bench for bus_bridge: stimulus queues expected values tagged with
// a cycle number, a negedge monitor compares them against the DUT.
module tb_bus_bridge;

    localparam int unsigned DRAM_AW = 14;

    localparam int K_RDATA  = 0;
    localparam int K_LED    = 1;
    localparam int K_DIGEN  = 2;
    localparam int K_SEG    = 3;
    localparam int K_DWE    = 4;
    localparam int K_DADDR  = 5;
    localparam int K_DWDATA = 6;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [31:0]        bus_addr;
    logic               bus_wen;
    logic [31:0]        bus_wdata;
    logic [31:0]        bus_rdata;
    logic [DRAM_AW-1:0] dram_addr;
    logic               dram_we;
    logic [31:0]        dram_wdata;
    logic [31:0]        dram_rdata;
    logic [23:0]        sw;
    logic [4:0]         btn;
    logic [23:0]        led;
    logic [7:0]         dig_en;
    logic [7:0]         seg;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    r_cyc;

    bus_bridge #(.SCAN_DIV(4), .DRAM_AW(DRAM_AW)) dut (
        .cpu_clk   (clk),
        .cpu_rst   (rst_n),
        .Bus_addr  (bus_addr),
        .Bus_wen   (bus_wen),
        .Bus_wdata (bus_wdata),
        .Bus_rdata (bus_rdata),
        .dram_addr (dram_addr),
        .dram_we   (dram_we),
        .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .sw        (sw),
        .btn       (btn),
        .led       (led),
        .dig_en    (dig_en),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_RDATA:  return bus_rdata;
            K_LED:    return {8'b0, led};
            K_DIGEN:  return {24'b0, dig_en};
            K_SEG:    return {24'b0, seg};
            K_DWE:    return {31'b0, dram_we};
            K_DADDR:  return 32'(dram_addr);
            default:  return dram_wdata;
        endcase
    endfunction

    // Monitor: compare every expectation due this cycle, flag any overdue one
    always @(negedge clk) begin
        int i;
        logic [31:0] act;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc == cyc) begin
                act = actual(q[i].kind);
                n_tests++;
                if (act !== q[i].exp) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", q[i].name, cyc, act, q[i].exp);
                end
                q.delete(i);
            end else if (q[i].cyc < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s overdue cyc=%0d got=none exp=%h", q[i].name, q[i].cyc, q[i].exp);
                q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int kind, input string name, input logic [31:0] v, input int d = 0);
        item_t it;
        it.cyc  = cyc + d;
        it.kind = kind;
        it.exp  = v;
        it.name = name;
        q.push_back(it);
    endtask

    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d);
        bus_addr  = a;
        bus_wen   = w;
        bus_wdata = d;
    endtask

    initial begin
        rst_n      = 1'b0;
        dram_rdata = 32'hCAFE_F00D;
        sw         = '0;
        btn        = '0;
        bus(32'hFFFF_F060, 1'b0, 32'h0);

        repeat (3) step();
        chk(K_DIGEN, "rst_digen", 32'hFE);
        chk(K_SEG,   "rst_seg",   32'hC0);
        chk(K_LED,   "rst_led",   32'h0);
        chk(K_RDATA, "rst_led_rd", 32'h0);
        step();

        // Display scan with SCAN_DIV=4
        rst_n = 1'b1;
        r_cyc = cyc;
        for (int t = 0; t <= 40; t++) begin
            bus(32'hFFFF_F000, 1'b0, 32'h0);
            if (t == 0)  bus(32'hFFFF_F000, 1'b1, 32'h0000_00F1);
            if (t == 35) bus(32'hFFFF_F000, 1'b1, 32'h0000_0B20);
            case (t)
                1:  chk(K_RDATA, "dig_rdback", 32'h0000_00F1);
                3:  begin chk(K_DIGEN, "scan3_en", 32'hFE); chk(K_SEG, "scan3_seg", 32'hC0); end
                4:  begin chk(K_DIGEN, "scan4_en", 32'hFD); chk(K_SEG, "scan4_seg", 32'h8E); end
                8:  begin chk(K_DIGEN, "scan8_en", 32'hFB); chk(K_SEG, "scan8_seg", 32'hC0); end
                31: begin chk(K_DIGEN, "scan31_en", 32'h7F); chk(K_SEG, "scan31_seg", 32'hC0); end
                32: begin chk(K_DIGEN, "wrap_en", 32'hFE); chk(K_SEG, "wrap_seg", 32'hF9); end
                36: begin chk(K_DIGEN, "race_en", 32'hFD); chk(K_SEG, "race_old_seg", 32'h8E); end
                37: chk(K_RDATA, "dig_new_rd", 32'h0000_0B20);
                40: begin chk(K_DIGEN, "race2_en", 32'hFB); chk(K_SEG, "race_new_seg", 32'h83); end
                default: ;
            endcase
            step();
        end

        // LED register and DRAM pass-through
        bus(32'hFFFF_F060, 1'b1, 32'hA5A5_A5A5);
        chk(K_DWE, "led_wr_dwe", 32'h0);
        step();
        bus(32'hFFFF_F060, 1'b0, 32'h0);
        chk(K_LED,   "led_out", 32'h00A5_A5A5);
        chk(K_RDATA, "led_rd",  32'h00A5_A5A5);
        step();
        bus(32'h0000_0010, 1'b1, 32'hDEAD_BEEF);
        chk(K_DWE,    "dram_wr_we",   32'h1);
        chk(K_DADDR,  "dram_wr_addr", 32'h4);
        chk(K_DWDATA, "dram_wr_data", 32'hDEAD_BEEF);
        step();
        bus(32'h0000_0010, 1'b0, 32'h0);
        chk(K_RDATA, "dram_rd",    32'hCAFE_F00D);
        chk(K_DWE,   "dram_rd_we", 32'h0);
        step();
        bus(32'hFFFF_F064, 1'b1, 32'h1234_5678);
        chk(K_DWE,   "near_led_dwe", 32'h1);
        chk(K_RDATA, "near_led_rd",  32'hCAFE_F00D);
        step();
        bus(32'hFFFF_F060, 1'b0, 32'h0);
        chk(K_RDATA, "led_kept", 32'h00A5_A5A5);
        step();

        // Switch synchroniser latency
        bus(32'hFFFF_F070, 1'b0, 32'h0);
        sw = 24'h00ABCD;
        chk(K_RDATA, "sw_lag0", 32'h0);
        chk(K_RDATA, "sw_lag1", 32'h0, 1);
        chk(K_RDATA, "sw_lag2", 32'h0000_ABCD, 2);
        repeat (3) step();

        // Single-cycle button pulse
        bus(32'hFFFF_F078, 1'b0, 32'h0);
        btn = 5'b10000;
        chk(K_RDATA, "btn_lag0", 32'h0);
        chk(K_RDATA, "btn_lag1", 32'h0, 1);
        chk(K_RDATA, "btn_pulse", 32'h10, 2);
        chk(K_RDATA, "btn_end", 32'h0, 3);
        step();
        btn = 5'b0;
        repeat (3) step();

        // Writes to the button address are ignored
        bus(32'hFFFF_F078, 1'b1, 32'hFFFF_FFFF);
        chk(K_DWE, "btn_wr_dwe", 32'h0);
        step();
        bus(32'hFFFF_F078, 1'b0, 32'h0);
        chk(K_RDATA, "btn_wr_rd", 32'h0);
        step();
        bus(32'hFFFF_F000, 1'b0, 32'h0);
        chk(K_RDATA, "btn_wr_dig", 32'h0000_0B20);
        chk(K_LED,   "btn_wr_led", 32'h00A5_A5A5);
        step();

        // Asynchronous reset in the middle of a digit slot
        bus(32'hFFFF_F000, 1'b1, 32'h1234_5678);
        step();
        bus(32'hFFFF_F000, 1'b0, 32'h0);
        for (int i = 0; i < 40; i++) begin
            step();
            if (i >= 5 && (((cyc - r_cyc) / 4) % 8) == 3 && ((cyc - r_cyc) % 4) == 2) break;
        end
        chk(K_DIGEN, "pre_rst_en",  32'hF7);
        chk(K_SEG,   "pre_rst_seg", 32'h92);
        step();
        rst_n = 1'b0;
        chk(K_DIGEN, "arst_en",  32'hFE);
        chk(K_SEG,   "arst_seg", 32'hC0);
        chk(K_LED,   "arst_led", 32'h0);
        chk(K_RDATA, "arst_dig_rd", 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();

        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL pending got=%0d items exp=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
